// File: rtl/io_stage_pkg.sv
// Shared types for the memory-response (io) pipeline stage: bus structs, FSM
// states and the helper that classifies memory operations.
package io_stage_params;

  typedef enum logic [1:0] {
    IO_EMPTY,
    IO_WAIT_DATA,
    IO_HOLD
  } io_state_t;

  typedef enum logic [1:0] {
    HL_MULT,
    HL_DIV,
    HL_MTHI,
    HL_MTLO
  } hl_op_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef struct packed {
    logic        valid;
    logic [31:0] program_count;
    logic [31:0] alu_result;
    logic [4:0]  write_register;
    logic        register_write;
    logic        exception;
    logic        eret;
    logic [4:0]  exception_code;
    logic        result_is_from_memory;
    logic        memory_write;
    logic [1:0]  memory_size;
    logic        memory_io_unsigned;
    logic        load_left;
    logic        load_right;
    logic [31:0] memory_address;
    logic [31:0] multi_use_register_data;
    logic [31:0] source_register_data;
    logic        high_low_write;
    hl_op_t      high_low_op;
    logic        multiply_signed;
    logic        result_high;
    logic        result_low;
    logic        is_mfc0;
    logic        divide_result_valid;
    logic [31:0] divide_quotient;
    logic [31:0] divide_remainder;
  } ex_to_io_bus_t;

  typedef struct packed {
    logic exception_valid;
    logic eret_flush;
  } wb_exception_bus_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] program_count;
    logic [31:0] final_result;
    logic [4:0]  write_register;
    logic        register_write;
    logic        exception;
    logic        eret;
    logic [4:0]  exception_code;
  } io_to_wb_bus_t;

  typedef struct packed {
    logic        valid;
    logic        data_valid;
    logic [4:0]  write_register;
    logic [31:0] write_data;
  } io_to_id_back_pass_bus_t;

  function automatic logic is_memory_op(input ex_to_io_bus_t bus);
    return bus.result_is_from_memory || bus.memory_write;
  endfunction

endpackage

// File: rtl/io_stage_load_aligner.sv
// Combinational load alignment: byte/half extraction with sign extension and
// the lwl/lwr merges against the old register value.
module load_aligner
  import io_stage_params::*;
(
  input  logic [31:0] memory_data,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        unsigned_load,
  input  logic        load_left,
  input  logic        load_right,
  input  logic [31:0] register_data,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel  = memory_data[{offset, 3'b000} +: 8];
    half_sel  = offset[1] ? memory_data[31:16] : memory_data[15:0];
    load_data = memory_data;
    if (load_left) begin
      case (offset)
        2'd0:    load_data = {memory_data[7:0],  register_data[23:0]};
        2'd1:    load_data = {memory_data[15:0], register_data[15:0]};
        2'd2:    load_data = {memory_data[23:0], register_data[7:0]};
        default: load_data = memory_data;
      endcase
    end else if (load_right) begin
      case (offset)
        2'd0:    load_data = memory_data;
        2'd1:    load_data = {register_data[31:24], memory_data[31:8]};
        2'd2:    load_data = {register_data[31:16], memory_data[31:16]};
        default: load_data = {register_data[31:8],  memory_data[31:24]};
      endcase
    end else if (size == SIZE_BYTE) begin
      load_data = unsigned_load ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
    end else if (size == SIZE_HALF) begin
      load_data = unsigned_load ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
    end
  end

endmodule

// File: rtl/io_stage.sv
// Memory-response stage: holds one instruction, waits for the data RAM
// response, owns HI/LO, and discards responses belonging to flushed ops.
module io_stage
  import io_stage_params::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  ex_to_io_bus_t           ex_to_io_bus,
  output logic                    io_allow_in,
  input  logic                    wb_allow_in,
  output io_to_wb_bus_t           io_to_wb_bus,
  output io_to_id_back_pass_bus_t io_to_id_back_pass_bus,
  input  wb_exception_bus_t       wb_exception_bus,
  output logic                    io_have_exception_forwards,
  input  logic                    data_ram_data_ok,
  input  logic [31:0]             data_ram_read_data
);

  io_state_t     state, next_state;
  ex_to_io_bus_t held;
  logic          io_valid, io_ready_go, handoff, accept_in, flush;
  logic          held_memory, held_divide, data_accept, kill_write;
  logic          discard_inc, discard_dec;
  logic [1:0]    discard_count;
  logic [31:0]   buffer, hi, lo, memory_data, loaded, final_result;
  logic [63:0]   signed_product, unsigned_product, product;

  assign flush       = wb_exception_bus.exception_valid || wb_exception_bus.eret_flush;
  assign held_memory = is_memory_op(held);
  assign held_divide = held.high_low_write && (held.high_low_op == HL_DIV);
  assign data_accept = data_ram_data_ok && (discard_count == 2'd0);
  assign kill_write  = held.exception || held.eret || flush;

  always_comb begin
    io_ready_go = 1'b1;
    if (held_memory) begin
      io_ready_go = ((state == IO_WAIT_DATA) && data_accept) || (state == IO_HOLD);
    end else if (held_divide) begin
      io_ready_go = held.divide_result_valid;
    end
  end

  assign io_allow_in = !io_valid || (io_ready_go && wb_allow_in);
  assign handoff     = io_valid && io_ready_go && wb_allow_in;
  assign accept_in   = ex_to_io_bus.valid && io_allow_in;

  always_comb begin
    next_state = state;
    if (flush) begin
      next_state = IO_EMPTY;
    end else if (io_allow_in) begin
      next_state = (accept_in && is_memory_op(ex_to_io_bus)) ? IO_WAIT_DATA : IO_EMPTY;
    end else if ((state == IO_WAIT_DATA) && data_accept) begin
      next_state = IO_HOLD;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IO_EMPTY;
    else       state <= next_state;
  end

  // A held divide keeps sampling the divider outputs until its result arrives.
  always_ff @(posedge clock) begin
    if (reset) begin
      io_valid <= 1'b0;
      held     <= '0;
      buffer   <= '0;
    end else begin
      if (flush)            io_valid <= 1'b0;
      else if (io_allow_in) io_valid <= ex_to_io_bus.valid;
      if (accept_in && !flush) begin
        held <= ex_to_io_bus;
      end else if (io_valid && held_divide) begin
        held.divide_result_valid <= ex_to_io_bus.divide_result_valid;
        held.divide_quotient     <= ex_to_io_bus.divide_quotient;
        held.divide_remainder    <= ex_to_io_bus.divide_remainder;
      end
      if ((state == IO_WAIT_DATA) && data_accept) buffer <= data_ram_read_data;
    end
  end

  // Every memory request killed before its response arrives leaves one
  // data_ok in flight that must not be mistaken for a later op's response.
  assign discard_inc = flush &&
                       ((io_valid && (state == IO_WAIT_DATA) && !data_accept) ||
                        (ex_to_io_bus.valid && is_memory_op(ex_to_io_bus)));
  assign discard_dec = data_ram_data_ok && (discard_count != 2'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      discard_count <= 2'd0;
    end else if (discard_inc && !discard_dec) begin
      if (discard_count != 2'd3) discard_count <= discard_count + 2'd1;
    end else if (discard_dec && !discard_inc) begin
      discard_count <= discard_count - 2'd1;
    end
  end

  assign signed_product   = $signed({{32{held.source_register_data[31]}}, held.source_register_data}) *
                            $signed({{32{held.multi_use_register_data[31]}}, held.multi_use_register_data});
  assign unsigned_product = {32'b0, held.source_register_data} * {32'b0, held.multi_use_register_data};
  assign product          = held.multiply_signed ? signed_product : unsigned_product;

  always_ff @(posedge clock) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (handoff && held.high_low_write && !kill_write) begin
      case (held.high_low_op)
        HL_MULT: {hi, lo} <= product;
        HL_DIV: begin
          lo <= held.divide_quotient;
          hi <= held.divide_remainder;
        end
        HL_MTHI: hi <= held.source_register_data;
        default: lo <= held.source_register_data;
      endcase
    end
  end

  assign memory_data = (state == IO_HOLD) ? buffer : data_ram_read_data;

  load_aligner u_load_aligner (
    .memory_data   (memory_data),
    .offset        (held.memory_address[1:0]),
    .size          (held.memory_size),
    .unsigned_load (held.memory_io_unsigned),
    .load_left     (held.load_left),
    .load_right    (held.load_right),
    .register_data (held.multi_use_register_data),
    .load_data     (loaded)
  );

  always_comb begin
    final_result = held.alu_result;
    if (held.result_is_from_memory) final_result = loaded;
    else if (held.result_high)      final_result = hi;
    else if (held.result_low)       final_result = lo;
  end

  assign io_to_wb_bus.valid          = io_valid && io_ready_go;
  assign io_to_wb_bus.program_count  = held.program_count;
  assign io_to_wb_bus.final_result   = final_result;
  assign io_to_wb_bus.write_register = held.write_register;
  assign io_to_wb_bus.register_write = held.register_write && !kill_write;
  assign io_to_wb_bus.exception      = held.exception;
  assign io_to_wb_bus.eret           = held.eret;
  assign io_to_wb_bus.exception_code = held.exception_code;

  assign io_to_id_back_pass_bus.valid          = io_valid && held.valid && held.register_write;
  assign io_to_id_back_pass_bus.data_valid     = io_valid && !held.is_mfc0 &&
                                                 (!held.result_is_from_memory || io_ready_go);
  assign io_to_id_back_pass_bus.write_register = held.write_register;
  assign io_to_id_back_pass_bus.write_data     = final_result;

  assign io_have_exception_forwards = io_valid && (held.exception || held.eret);

endmodule

// File: tb/tb_io_stage.sv
// Directed bench for io_stage: loads, alignment, back-pressure, flush
// discard and HI/LO behaviour against hand-computed values.
module tb_io_stage;
  import io_stage_params::*;

  logic                    clock = 1'b0;
  logic                    reset;
  ex_to_io_bus_t           ex_bus;
  logic                    io_allow_in;
  logic                    wb_allow_in;
  io_to_wb_bus_t           wb_bus;
  io_to_id_back_pass_bus_t back_bus;
  wb_exception_bus_t       exc_bus;
  logic                    have_exception;
  logic                    data_ok;
  logic [31:0]             read_data;

  int check_count = 0;
  int pass_count  = 0;

  io_stage dut (
    .clock                      (clock),
    .reset                      (reset),
    .ex_to_io_bus               (ex_bus),
    .io_allow_in                (io_allow_in),
    .wb_allow_in                (wb_allow_in),
    .io_to_wb_bus               (wb_bus),
    .io_to_id_back_pass_bus     (back_bus),
    .wb_exception_bus           (exc_bus),
    .io_have_exception_forwards (have_exception),
    .data_ram_data_ok           (data_ok),
    .data_ram_read_data         (read_data)
  );

  always #5 clock = ~clock;

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
  endtask

  // One clock; single-cycle pulses are dropped and outputs sampled 1ns after the falling edge.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    ex_bus.valid            = 1'b0;
    data_ok                 = 1'b0;
    exc_bus                 = '0;
    #1;
  endtask

  task automatic apply_stimulus(input ex_to_io_bus_t b);
    ex_bus       = b;
    ex_bus.valid = 1'b1;
    tick();
  endtask

  function automatic ex_to_io_bus_t load_op(input logic [31:0] addr, input logic [1:0] size,
                                            input logic uns, input logic left, input logic right,
                                            input logic [31:0] rt);
    ex_to_io_bus_t b;
    b = '0;
    b.result_is_from_memory   = 1'b1;
    b.register_write          = 1'b1;
    b.write_register          = 5'd8;
    b.memory_address          = addr;
    b.memory_size             = size;
    b.memory_io_unsigned      = uns;
    b.load_left               = left;
    b.load_right              = right;
    b.multi_use_register_data = rt;
    return b;
  endfunction

  function automatic ex_to_io_bus_t hl_op(input hl_op_t op, input logic [31:0] rs, input logic [31:0] rt);
    ex_to_io_bus_t b;
    b = '0;
    b.high_low_write          = 1'b1;
    b.high_low_op             = op;
    b.multiply_signed         = 1'b1;
    b.source_register_data    = rs;
    b.multi_use_register_data = rt;
    return b;
  endfunction

  function automatic ex_to_io_bus_t move_from(input logic high);
    ex_to_io_bus_t b;
    b = '0;
    b.register_write = 1'b1;
    b.write_register = 5'd9;
    b.result_high    = high;
    b.result_low     = !high;
    return b;
  endfunction

  // Issues a load, returns data_ok one cycle later and checks the delivered value.
  task automatic run_load(input string tag, input ex_to_io_bus_t b, input logic [31:0] mem,
                          input logic [31:0] expected);
    apply_stimulus(b);
    data_ok   = 1'b1;
    read_data = mem;
    #1;
    check_output({tag, "_valid"}, {31'b0, wb_bus.valid}, 32'd1);
    check_output({tag, "_result"}, wb_bus.final_result, expected);
    tick();
  endtask

  initial begin
    ex_to_io_bus_t b;
    reset       = 1'b1;
    ex_bus      = '0;
    exc_bus     = '0;
    wb_allow_in = 1'b1;
    data_ok     = 1'b0;
    read_data   = '0;
    @(negedge clock);
    tick();
    tick();
    reset = 1'b0;
    #1;
    check_output("reset_wb_valid", {31'b0, wb_bus.valid}, 32'd0);
    check_output("reset_back_valid", {31'b0, back_bus.valid}, 32'd0);
    check_output("reset_allow_in", {31'b0, io_allow_in}, 32'd1);
    check_output("reset_exception", {31'b0, have_exception}, 32'd0);
    check_output("reset_discard", {30'b0, dut.discard_count}, 32'd0);

    // lw with a one-cycle response and an open write-back stage
    apply_stimulus(load_op(32'h100, SIZE_WORD, 1'b0, 1'b0, 1'b0, 32'h0));
    check_output("lw_wait_valid", {31'b0, wb_bus.valid}, 32'd0);
    check_output("lw_wait_back_valid", {31'b0, back_bus.valid}, 32'd1);
    check_output("lw_wait_data_valid", {31'b0, back_bus.data_valid}, 32'd0);
    data_ok   = 1'b1;
    read_data = 32'h8899AABB;
    #1;
    check_output("lw_valid", {31'b0, wb_bus.valid}, 32'd1);
    check_output("lw_result", wb_bus.final_result, 32'h8899AABB);
    check_output("lw_data_valid", {31'b0, back_bus.data_valid}, 32'd1);
    tick();
    check_output("lw_single_handoff", {31'b0, wb_bus.valid}, 32'd0);

    run_load("lb", load_op(32'h103, SIZE_BYTE, 1'b0, 1'b0, 1'b0, 32'h0), 32'h80112233, 32'hFFFFFF80);
    run_load("lbu", load_op(32'h103, SIZE_BYTE, 1'b1, 1'b0, 1'b0, 32'h0), 32'h80112233, 32'h00000080);
    run_load("lh", load_op(32'h102, SIZE_HALF, 1'b0, 1'b0, 1'b0, 32'h0), 32'h80112233, 32'hFFFF8011);
    run_load("lhu", load_op(32'h100, SIZE_HALF, 1'b1, 1'b0, 1'b0, 32'h0), 32'h0011A233, 32'h0000A233);
    run_load("lwl", load_op(32'h101, SIZE_WORD, 1'b0, 1'b1, 1'b0, 32'h11223344), 32'hAABBCCDD, 32'hCCDD3344);
    run_load("lwr", load_op(32'h102, SIZE_WORD, 1'b0, 1'b0, 1'b1, 32'h11223344), 32'hAABBCCDD, 32'h1122AABB);

    // Response arrives while write-back is blocked for three cycles
    wb_allow_in = 1'b0;
    apply_stimulus(load_op(32'h200, SIZE_WORD, 1'b0, 1'b0, 1'b0, 32'h0));
    data_ok   = 1'b1;
    read_data = 32'h12345678;
    #1;
    check_output("hold_allow_in", {31'b0, io_allow_in}, 32'd0);
    tick();
    read_data = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      check_output("hold_valid", {31'b0, wb_bus.valid}, 32'd1);
      check_output("hold_result", wb_bus.final_result, 32'h12345678);
      tick();
    end
    wb_allow_in = 1'b1;
    #1;
    check_output("hold_release_allow_in", {31'b0, io_allow_in}, 32'd1);
    tick();
    check_output("hold_single_handoff", {31'b0, wb_bus.valid}, 32'd0);

    // Flush a waiting lw; its late response must be swallowed
    apply_stimulus(load_op(32'h300, SIZE_WORD, 1'b0, 1'b0, 1'b0, 32'h0));
    exc_bus.exception_valid = 1'b1;
    tick();
    check_output("flush_cleared", {31'b0, wb_bus.valid | back_bus.valid}, 32'd0);
    check_output("flush_discard_one", {30'b0, dut.discard_count}, 32'd1);
    apply_stimulus(load_op(32'h304, SIZE_WORD, 1'b0, 1'b0, 1'b0, 32'h0));
    data_ok   = 1'b1;
    read_data = 32'h11111111;
    #1;
    check_output("flush_swallowed", {31'b0, wb_bus.valid}, 32'd0);
    tick();
    check_output("flush_discard_zero", {30'b0, dut.discard_count}, 32'd0);
    data_ok   = 1'b1;
    read_data = 32'h22222222;
    #1;
    check_output("flush_second_valid", {31'b0, wb_bus.valid}, 32'd1);
    check_output("flush_second_result", wb_bus.final_result, 32'h22222222);
    tick();

    // Signed mult then reads of HI/LO
    apply_stimulus(hl_op(HL_MULT, 32'h80000000, 32'h2));
    check_output("mult_valid", {31'b0, wb_bus.valid}, 32'd1);
    apply_stimulus(move_from(1'b1));
    check_output("mfhi", wb_bus.final_result, 32'hFFFFFFFF);
    apply_stimulus(move_from(1'b0));
    check_output("mflo", wb_bus.final_result, 32'h00000000);

    // Same mult carrying an exception must not touch HI/LO or the register file
    b                = hl_op(HL_MULT, 32'h3, 32'h4);
    b.exception      = 1'b1;
    b.register_write = 1'b1;
    apply_stimulus(b);
    check_output("exc_forward", {31'b0, have_exception}, 32'd1);
    check_output("exc_reg_write", {31'b0, wb_bus.register_write}, 32'd0);
    apply_stimulus(move_from(1'b1));
    check_output("exc_mfhi", wb_bus.final_result, 32'hFFFFFFFF);
    apply_stimulus(move_from(1'b0));
    check_output("exc_mflo", wb_bus.final_result, 32'h00000000);

    // Divide stalls until the divider reports completion
    b                  = hl_op(HL_DIV, 32'd15, 32'd2);
    b.divide_quotient  = 32'd7;
    b.divide_remainder = 32'd1;
    apply_stimulus(b);
    check_output("div_stall_valid", {31'b0, wb_bus.valid}, 32'd0);
    check_output("div_stall_allow_in", {31'b0, io_allow_in}, 32'd0);
    tick();
    check_output("div_stall_valid2", {31'b0, wb_bus.valid}, 32'd0);
    ex_bus.divide_result_valid = 1'b1;
    tick();
    check_output("div_done_valid", {31'b0, wb_bus.valid}, 32'd1);
    apply_stimulus(move_from(1'b0));
    check_output("div_quotient", wb_bus.final_result, 32'd7);
    apply_stimulus(move_from(1'b1));
    check_output("div_remainder", wb_bus.final_result, 32'd1);

    // mthi without exception and mfc0 forwarding
    apply_stimulus(hl_op(HL_MTHI, 32'hABCD0123, 32'h0));
    apply_stimulus(move_from(1'b1));
    check_output("mthi", wb_bus.final_result, 32'hABCD0123);
    b                = '0;
    b.is_mfc0        = 1'b1;
    b.register_write = 1'b1;
    b.alu_result     = 32'h55;
    apply_stimulus(b);
    check_output("mfc0_back_valid", {31'b0, back_bus.valid}, 32'd1);
    check_output("mfc0_data_valid", {31'b0, back_bus.data_valid}, 32'd0);
    tick();

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
